vga_regview: RTL and testbench
==============================

// Module: vga_regview
// PURPOSE
//  Downstream consumer of the CPU writeback port. Snoops register writes into an 8x16 shadow file
//  and drives the board VGA output as a 640x480@60Hz bit map: one cell per register bit.
//  Rows are registers r0..r7 (top to bottom). Columns are bits 15..0 (left to right).
//  The display copy is refreshed once per frame, at the start of vertical blanking, so frames never tear.
// PARAMETERS
//  CLK_DIV   4    CLK cycles per pixel (100MHz -> 25MHz pixel enable)
//  CELL_W    40   cell width in pixels (16 cells x 40 = 640)
//  CELL_H    60   cell height in lines (8 cells x 60 = 480)
// PORTS
//  CLK          in   1    system clock, 100MHz
//  RST          in   1    reset: synchronous, active-high
//  wb_we        in   1    writeback register-write enable
//  wb_addr      in   3    writeback destination register
//  wb_data      in   16   writeback data
//  VGA          out  7    {HS, VS, R[1:0], G[1:0], B}; HS and VS are active-low
//  frame_start  out  1    one-CLK pulse on the pixel tick where h=0, v=0
// BEHAVIOUR
//  - Reset values: VGA=7'b1100000 (sync lines idle high, colour black); frame_start=0.
//    All counters=0; shadow, display copy and last_wr=0.
//  - Pixel enable pe: CLK_DIV-counter; pe=1 in the cycle the counter wraps to 0.
//    The first pe occurs CLK_DIV cycles after RST deasserts.
//  - On pe, h counts 0..799. On the h wrap, v counts 0..524.
//    Both counters wrap to 0 (799->0; 524->0 together with h 799->0).
//  - HS=0 for h in 656..751. VS=0 for v in 490..491. Active region: h<640 and v<480.
//  - Cell tracking uses no divider. cx counts 0..CELL_W-1; on wrap, col steps 0..15.
//    cy/row do the same, stepping on each line end. All four reset to 0 at h=0 and v=0 respectively.
//  - Snoop: wb_we=1 writes shadow[wb_addr]<=wb_data and last_wr<=wb_addr in the same CLK.
//    A write is never dropped, whatever the display state.
//  - Commit: the pe tick with h=0, v=480 copies shadow->display (all 8 regs) and last_wr->disp_last.
//    If wb_we is asserted in that same CLK, the copy takes the pre-write shadow value.
//    The new value appears one frame later.
//  - Pixel colour, active region only (black elsewhere):
//    - b = display[row][15-col].
//    - Row == disp_last: b=1 gives R=11,G=00,B=0; b=0 gives all 0.
//    - Other rows: b=1 gives R=00,G=11,B=0; b=0 gives R=00,G=00,B=1.
//  - Latency: VGA is registered and updates only on pe.
//    Colour and sync for counter state (h,v) appear together on the next pe tick, 1 pixel late uniformly.
//  - RST mid-frame: the next CLK returns everything to reset values and the frame restarts at h=v=0.
// CONFIGURATION
//  VGA_GRID_EN defined: pixels with cx==0 or cy==0 inside the active region are forced to
//  R=01,G=01,B=1 (grey grid), overriding bit colour.
//  VGA_GRID_EN undefined: no grid; every active pixel takes its bit colour.
// STRUCTURE
//  - Package archel_vga_pkg holds the timing constants:
//    H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33.
//    It also holds the derived H_TOTAL/V_TOTAL and the VGA bit-index constants.
//  - One sub-module, vga_timing: pe divider, h/v counters, HS/VS and active flags.
//    Shadow/display storage and colour logic stay in vga_regview.
// TESTING
//  1 Reset then free-run 2 frames.
//    HS low for 96 pixel ticks every 800. VS low for exactly 2 lines every 525.
//    frame_start has a period of 1,680,000 CLK.
//  2 Write r3<=16'h8001 mid-frame.
//    Current frame shows the old value. Next frame: row 3 cells at cols 0 and 15 are red, the others black.
//    Rows 0..2 and 4..7 show blue.
//  3 Two back-to-back writes, r0<=16'hFFFF then r7<=16'h0001.
//    Next frame: row 0 all green, row 7 col 15 red, disp_last=7.
//  4 wb_we with r5<=16'h00FF in the same CLK as the commit tick.
//    Row 5 is unchanged in the next frame and shows 16'h00FF in the frame after.
//  5 Assert RST at h=300, v=200 for 1 CLK.
//    VGA=7'b1100000 next CLK. Shadow cleared (all cells blue). Next HS falls at h=656 of the restarted line.
//  6 Build with VGA_GRID_EN and display pixel h=40, v=60 (cx==0).
//    Pixel output is grey, 7'b1101011. Without the macro the same pixel shows its bit colour.

Source files
------------

// File: rtl/archel_vga_pkg.sv
// Shared VGA timing constants, colour codes and output-word helper for the register viewer.
// The VGA_GRID_EN build option is handled in vga_regview; nothing here depends on it.
package archel_vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int VGA_HS_BIT  = 6;
    localparam int VGA_VS_BIT  = 5;
    localparam int VGA_RGB_MSB = 4;

    localparam logic [6:0] VGA_RESET = 7'b1100000;

    // {R[1:0], G[1:0], B}
    typedef enum logic [4:0] {
        RGB_BLACK = 5'b00000,
        RGB_BLUE  = 5'b00001,
        RGB_GREEN = 5'b00110,
        RGB_GREY  = 5'b01011,
        RGB_RED   = 5'b11000
    } rgb_t;

    function automatic logic [6:0] vga_word(input logic hs, input logic vs, input rgb_t rgb);
        logic [6:0] w;
        w = '0;
        w[VGA_HS_BIT] = hs;
        w[VGA_VS_BIT] = vs;
        w[VGA_RGB_MSB:0] = rgb;
        return w;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, horizontal/vertical counters and the sync/active decodes derived from them.
module vga_timing import archel_vga_pkg::*; #(
    parameter int CLK_DIV = 4,
    parameter int HACT    = H_ACTIVE,
    parameter int HFP     = H_FP,
    parameter int HSW     = H_SYNC,
    parameter int HBP     = H_BP,
    parameter int VACT    = V_ACTIVE,
    parameter int VFP     = V_FP,
    parameter int VSW     = V_SYNC,
    parameter int VBP     = V_BP
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       pe,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       hs,
    output logic       vs,
    output logic       active
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(HACT + HFP + HSW + HBP - 1);
    localparam logic [9:0] V_LAST   = 10'(VACT + VFP + VSW + VBP - 1);
    localparam logic [9:0] HS_BEG   = 10'(HACT + HFP);
    localparam logic [9:0] HS_END   = 10'(HACT + HFP + HSW);
    localparam logic [9:0] VS_BEG   = 10'(VACT + VFP);
    localparam logic [9:0] VS_END   = 10'(VACT + VFP + VSW);
    localparam logic [9:0] H_ACT    = 10'(HACT);
    localparam logic [9:0] V_ACT    = 10'(VACT);

    logic [7:0] div_cnt;

    always_ff @(posedge CLK) begin
        if (RST)
            div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 8'd1;
    end

    assign pe = (div_cnt == DIV_LAST) && !RST;

    // v advances only when h wraps, so both return to 0 on the same tick
    always_ff @(posedge CLK) begin
        if (RST) begin
            h <= '0;
            v <= '0;
        end else if (pe) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    assign hs     = !((h >= HS_BEG) && (h < HS_END));
    assign vs     = !((v >= VS_BEG) && (v < VS_END));
    assign active = (h < H_ACT) && (v < V_ACT);

endmodule

// File: rtl/vga_regview.sv
// Snoops CPU register writes into an 8x16 shadow file and shows it as a VGA bit map, one cell per bit.
// Define VGA_GRID_EN to overlay a grey grid on the first pixel row/column of every cell.
module vga_regview import archel_vga_pkg::*; #(
    parameter int CLK_DIV = 4,
    parameter int CELL_W  = 40,
    parameter int CELL_H  = 60,
    parameter int HACT    = H_ACTIVE,
    parameter int HFP     = H_FP,
    parameter int HSW     = H_SYNC,
    parameter int HBP     = H_BP,
    parameter int VACT    = V_ACTIVE,
    parameter int VFP     = V_FP,
    parameter int VSW     = V_SYNC,
    parameter int VBP     = V_BP
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wb_we,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic [6:0]  VGA,
    output logic        frame_start
);

    localparam logic [9:0] H_LAST   = 10'(HACT + HFP + HSW + HBP - 1);
    localparam logic [9:0] V_LAST   = 10'(VACT + VFP + VSW + VBP - 1);
    localparam logic [9:0] V_COMMIT = 10'(VACT);
    localparam logic [7:0] CX_LAST  = 8'(CELL_W - 1);
    localparam logic [7:0] CY_LAST  = 8'(CELL_H - 1);

    logic        pe, hs, vs, active;
    logic [9:0]  h, v;
    logic [15:0] shadow  [0:7];
    logic [15:0] display [0:7];
    logic [2:0]  last_wr, disp_last;
    logic [7:0]  cx, cy;
    logic [3:0]  col;
    logic [2:0]  row;
    rgb_t        rgb;
    logic        bit_on;

    vga_timing #(
        .CLK_DIV(CLK_DIV), .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP)
    ) u_timing (
        .CLK(CLK), .RST(RST), .pe(pe), .h(h), .v(v),
        .hs(hs), .vs(vs), .active(active)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
            last_wr <= '0;
        end else if (wb_we) begin
            shadow[wb_addr] <= wb_data;
            last_wr <= wb_addr;
        end
    end

    // Non-blocking copy means a write in the commit cycle lands in the following frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) display[i] <= '0;
            disp_last <= '0;
        end else if (pe && (h == 10'd0) && (v == V_COMMIT)) begin
            for (int i = 0; i < 8; i++) display[i] <= shadow[i];
            disp_last <= last_wr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cx  <= '0;
            col <= '0;
            cy  <= '0;
            row <= '0;
        end else if (pe) begin
            if (h == H_LAST) begin
                cx  <= '0;
                col <= '0;
                if (v == V_LAST) begin
                    cy  <= '0;
                    row <= '0;
                end else if (cy == CY_LAST) begin
                    cy  <= '0;
                    row <= row + 3'd1;
                end else begin
                    cy <= cy + 8'd1;
                end
            end else if (cx == CX_LAST) begin
                cx  <= '0;
                col <= col + 4'd1;
            end else begin
                cx <= cx + 8'd1;
            end
        end
    end

    always_comb begin
        rgb    = RGB_BLACK;
        bit_on = display[row][4'd15 - col];
        if (active) begin
            if (row == disp_last)
                rgb = bit_on ? RGB_RED : RGB_BLACK;
            else
                rgb = bit_on ? RGB_GREEN : RGB_BLUE;
`ifdef VGA_GRID_EN
            if ((cx == 8'd0) || (cy == 8'd0))
                rgb = RGB_GREY;
`else
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            VGA <= VGA_RESET;
        else if (pe)
            VGA <= vga_word(hs, vs, rgb);
    end

    assign frame_start = pe && (h == 10'd0) && (v == 10'd0);

endmodule

// File: tb/tb_vga_regview.sv
// Self-checking bench for vga_regview on a shrunken raster, against a tick-arithmetic reference model.
module tb_vga_regview;

    localparam int DIV = 2, CW = 4, CH = 3;
    localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
    localparam int VA = 24, VFP = 2, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME_CLK = HT * VT * DIV;
    localparam logic [6:0] PX_BLACK = 7'b1100000, PX_BLUE = 7'b1100001;
    localparam logic [6:0] PX_GREEN = 7'b1100110, PX_RED  = 7'b1111000;
    localparam logic [6:0] PX_GREY  = 7'b1101011;

    logic        CLK = 1'b0, RST = 1'b1, wb_we = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic [6:0]  VGA;
    logic        frame_start;

    int errors = 0, checks = 0;

    always #5 CLK = ~CLK;

    vga_regview #(
        .CLK_DIV(DIV), .CELL_W(CW), .CELL_H(CH),
        .HACT(HA), .HFP(HFP), .HSW(HSY), .HBP(HBP),
        .VACT(VA), .VFP(VFP), .VSW(VSY), .VBP(VBP)
    ) dut (
        .CLK(CLK), .RST(RST), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .VGA(VGA), .frame_start(frame_start)
    );

    // Reference model: k counts clocks since reset, pixel tick t = k/DIV-1 maps to (t%HT, t/HT%VT)
    int          k, m_t, m_h, m_v, m_last, m_dlast;
    bit          m_pe_edge;
    logic [15:0] m_shadow [0:7];
    logic [15:0] m_disp   [0:7];
    logic [6:0]  exp_vga;
    logic        exp_fs;

    function automatic logic [6:0] pixel(input int h, input int v);
        logic [4:0] rgb;
        logic b;
        int row, col;
        rgb = 5'b00000;
        if (h < HA && v < VA) begin
            row = v / CH;
            col = h / CW;
            b = m_disp[row][15 - col];
            if (row == m_dlast) rgb = b ? 5'b11000 : 5'b00000;
            else                rgb = b ? 5'b00110 : 5'b00001;
`ifdef VGA_GRID_EN
            if (h % CW == 0 || v % CH == 0) rgb = 5'b01011;
`endif
        end
        return {!(h >= HA + HFP && h < HA + HFP + HSY), !(v >= VA + VFP && v < VA + VFP + VSY), rgb};
    endfunction

    function automatic bit nextTickIs(input int h, input int v);
        int t;
        t = (k + 1) / DIV - 1;
        return ((k + 1) % DIV == 0) && (t % HT == h) && ((t / HT) % VT == v);
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            k = 0; m_h = 0; m_v = 0; m_pe_edge = 0; m_last = 0; m_dlast = 0;
            for (int i = 0; i < 8; i++) begin m_shadow[i] = '0; m_disp[i] = '0; end
            exp_vga = 7'b1100000;
        end else begin
            k++;
            m_pe_edge = (k % DIV == 0);
            if (m_pe_edge) begin
                m_t = k / DIV - 1;
                m_h = m_t % HT;
                m_v = (m_t / HT) % VT;
                exp_vga = pixel(m_h, m_v);
                if (m_h == 0 && m_v == VA) begin
                    for (int i = 0; i < 8; i++) m_disp[i] = m_shadow[i];
                    m_dlast = m_last;
                end
            end
            if (wb_we) begin
                m_shadow[wb_addr] = wb_data;
                m_last = int'(wb_addr);
            end
        end
        exp_fs = nextTickIs(0, 0);
    end

    task automatic checkOutput(input string tag);
        checks++;
        assert (VGA === exp_vga) else begin
            errors++;
            $error("[TB] FAIL %s VGA: observed %b expected %b (tick h=%0d v=%0d)", tag, VGA, exp_vga, m_h, m_v);
        end
        checks++;
        assert (frame_start === exp_fs) else begin
            errors++;
            $error("[TB] FAIL %s frame_start: observed %b expected %b (k=%0d)", tag, frame_start, exp_fs, k);
        end
    endtask

    task automatic checkInt(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycle(input string tag);
        @(negedge CLK);
        checkOutput(tag);
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [15:0] data);
        wb_we = we;
        wb_addr = addr;
        wb_data = data;
    endtask

    task automatic waitTick(input int h, input int v, input string tag);
        int n;
        bit found;
        n = 0;
        found = 0;
        while (!found && n < 3 * FRAME_CLK) begin
            stepCycle(tag);
            n++;
            found = m_pe_edge && m_h == h && m_v == v;
        end
        checkInt({tag, " reached"}, int'(found), 1);
    endtask

    task automatic waitNextTick(input int h, input int v, input string tag);
        int n;
        n = 0;
        while (!nextTickIs(h, v) && n < 3 * FRAME_CLK) begin
            stepCycle(tag);
            n++;
        end
        checkInt({tag, " reached"}, int'(nextTickIs(h, v)), 1);
    endtask

    task automatic checkPixelAt(input int h, input int v, input logic [6:0] expv, input string tag);
        waitTick(h, v, tag);
        checks++;
        assert (VGA === expv) else begin
            errors++;
            $error("[TB] FAIL %s pixel(%0d,%0d): observed %b expected %b", tag, h, v, VGA, expv);
        end
    endtask

    initial begin
        int hs_low, vs_low, fs_cnt, fs_first, fs_period, n;

        $display("[TB] reset and free-run");
        repeat (3) @(negedge CLK);
        checkOutput("reset");
        checkInt("reset VGA", int'(VGA), int'(PX_BLACK));
        checkInt("reset frame_start", int'(frame_start), 0);
        RST = 1'b0;

        hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = 0; fs_period = 0;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            stepCycle("free-run");
            if (m_pe_edge) begin
                if (!VGA[6]) hs_low++;
                if (!VGA[5]) vs_low++;
            end
            if (frame_start === 1'b1) begin
                if (fs_cnt == 0) fs_first = k;
                if (fs_cnt == 1) fs_period = k - fs_first;
                fs_cnt++;
            end
        end
        checkInt("hs low ticks", hs_low, 2 * VT * HSY);
        checkInt("vs low ticks", vs_low, 2 * VSY * HT);
        checkInt("frame_start count", fs_cnt, 2);
        checkInt("frame_start period", fs_period, FRAME_CLK);

        $display("[TB] mid-frame write r3");
        waitTick(10, 10, "w3 pos");
        applyStimulus(1'b1, 3'd3, 16'h8001);
        stepCycle("w3");
        applyStimulus(1'b0, 3'd0, 16'h0000);
        checkPixelAt(21, 10, PX_BLUE, "r3 old");
        checkPixelAt(1, 7, PX_BLUE, "r2 blue");
        checkPixelAt(1, 10, PX_RED, "r3 c0");
        checkPixelAt(29, 10, PX_BLACK, "r3 c7");
        checkPixelAt(61, 10, PX_RED, "r3 c15");
        checkPixelAt(1, 13, PX_BLUE, "r4 blue");

        $display("[TB] back-to-back writes");
        applyStimulus(1'b1, 3'd0, 16'hFFFF);
        stepCycle("w0");
        applyStimulus(1'b1, 3'd7, 16'h0001);
        stepCycle("w7");
        applyStimulus(1'b0, 3'd0, 16'h0000);
        checkPixelAt(21, 1, PX_GREEN, "r0 green");
        checkPixelAt(1, 10, PX_GREEN, "r3 green");
        checkPixelAt(1, 22, PX_BLACK, "r7 c0");
        checkPixelAt(61, 22, PX_RED, "r7 c15");

        $display("[TB] write on commit tick");
        waitNextTick(0, VA, "commit pos");
        applyStimulus(1'b1, 3'd5, 16'h00FF);
        stepCycle("w5");
        applyStimulus(1'b0, 3'd0, 16'h0000);
        checkPixelAt(61, 16, PX_BLUE, "r5 unchanged");
        checkPixelAt(1, 16, PX_BLACK, "r5 c0 later");
        checkPixelAt(61, 16, PX_RED, "r5 c15 later");

        $display("[TB] mid-frame reset");
        waitNextTick(30, 14, "rst pos");
        applyStimulus(1'b1, 3'd2, 16'h1234);
        RST = 1'b1;
        stepCycle("rst");
        checkInt("rst VGA", int'(VGA), int'(PX_BLACK));
        checkInt("rst frame_start", int'(frame_start), 0);
        RST = 1'b0;
        applyStimulus(1'b0, 3'd0, 16'h0000);
        n = 0;
        while (VGA[6] !== 1'b0 && n < 4 * HT * DIV) begin
            stepCycle("hs wait");
            n++;
        end
        checkInt("hs fall h", m_h, HA + HFP);
        checkInt("hs fall v", m_v, 0);
        checkPixelAt(21, 4, PX_BLUE, "cleared r1");
        checkPixelAt(61, 22, PX_BLUE, "cleared r7");

        $display("[TB] grid pixel");
`ifdef VGA_GRID_EN
        checkPixelAt(CW, CH, PX_GREY, "grid");
`else
        checkPixelAt(CW, CH, PX_BLUE, "no grid");
`endif
        stepCycle("tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
